// File: rtl/adc_capture_ctrl.sv
// Triggered, decimated ADC capture sequencer feeding a 1-entry out_en/outbusy holding register.
// Optional level trigger enabled by defining ADC_CAPTURE_LEVEL_TRIG_EN.
module adc_capture_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int DEC_W      = 8,
    parameter int LEN_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] dataIn,
    input  logic                         data_valid,
    input  logic        [DEC_W-1:0]      decim,
    input  logic        [LEN_W-1:0]      cap_len,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         trig,
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    input  logic signed [DATA_WIDTH-1:0] trig_level,
    input  logic                         trig_sel,
`endif
    output logic        [DATA_WIDTH-1:0] dsoutdata,
    output logic                         out_en,
    input  logic                         outbusy,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [DEC_W-1:0] dec_lat, dec_cnt;
    logic [LEN_W-1:0] len_lat, emit_cnt, emit_nxt;
    logic             xfer, hold_free, kept, load, drop, arm_req, abort_eff, fire;

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic signed [DATA_WIDTH-1:0] prev_sample;

    always_comb begin
        fire = trig;
        if (trig_sel)
            fire = data_valid && (prev_sample < trig_level) && (dataIn >= trig_level);
    end
`else
    always_comb fire = trig;
`endif

    always_comb begin
        xfer      = out_en && !outbusy;
        hold_free = !out_en || xfer;
        kept      = (state == CAPTURE) && data_valid && (dec_cnt == '0);
        load      = kept && hold_free;
        drop      = kept && !hold_free;
        abort_eff = abort && (state != IDLE);
        arm_req   = start && !abort && ((state == IDLE) || (state == DONE));
        emit_nxt  = emit_cnt + LEN_W'(1);
    end

    always_comb begin
        state_nxt = state;
        if (abort_eff) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (arm_req) state_nxt = ARMED;
                ARMED:      if (fire) state_nxt = CAPTURE;
                CAPTURE:    if (load && (len_lat != '0) && (emit_nxt == len_lat)) state_nxt = DRAIN;
                DRAIN:      if (hold_free) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dec_lat   <= '0;
            len_lat   <= '0;
            dec_cnt   <= '0;
            emit_cnt  <= '0;
            dsoutdata <= '0;
            out_en    <= 1'b0;
            overrun   <= 1'b0;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
            prev_sample <= MOST_NEG;
`endif
        end else begin
            state <= state_nxt;
            if (arm_req) begin
                dec_lat <= decim;
                len_lat <= cap_len;
                overrun <= 1'b0;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
                prev_sample <= MOST_NEG;
`endif
            end
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
            if ((state == ARMED) && data_valid)
                prev_sample <= dataIn;
`endif
            if ((state == ARMED) && fire) begin
                dec_cnt  <= '0;
                emit_cnt <= '0;
            end
            // Decimation phase advances on every valid sample, kept or dropped.
            if ((state == CAPTURE) && data_valid)
                dec_cnt <= (dec_cnt == dec_lat) ? '0 : dec_cnt + DEC_W'(1);
            if (load)
                emit_cnt <= emit_nxt;
            if (drop)
                overrun <= 1'b1;
            if (abort_eff) begin
                out_en <= 1'b0;
            end else if (load) begin
                dsoutdata <= {~dataIn[DATA_WIDTH-1], dataIn[DATA_WIDTH-2:0]};
                out_en    <= 1'b1;
            end else if (xfer) begin
                out_en <= 1'b0;
            end
        end
    end

    assign busy = (state == ARMED) || (state == CAPTURE) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: conversion table, randomized capture runs
// against an arithmetic stream model, and hand-written stall/abort/arming sequences.
module tb_adc_capture_ctrl;
    localparam int DW   = 14;
    localparam int DECW = 8;
    localparam int LENW = 16;

    logic            clk = 1'b0;
    logic            rst, data_valid, start, abort, trig, outbusy;
    logic [DW-1:0]   dataIn;
    logic [DECW-1:0] decim;
    logic [LENW-1:0] cap_len;
    logic [DW-1:0]   dsoutdata;
    logic            out_en, busy, done, overrun;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    logic [DW-1:0]   trig_level;
    logic            trig_sel;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic mon_en = 1'b0;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tab[6];

    always #5 clk = ~clk;

    adc_capture_ctrl #(.DATA_WIDTH(DW), .DEC_W(DECW), .LEN_W(LENW)) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .data_valid(data_valid),
        .decim(decim), .cap_len(cap_len), .start(start), .abort(abort), .trig(trig),
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
        .trig_level(trig_level), .trig_sel(trig_sel),
`endif
        .dsoutdata(dsoutdata), .out_en(out_en), .outbusy(outbusy),
        .busy(busy), .done(done), .overrun(overrun)
    );

    function automatic logic [DW-1:0] ofs(input logic [DW-1:0] x);
        int v;
        v = int'($signed(x)) + (1 << (DW - 1));
        return DW'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0; trig = 0; data_valid = 0; outbusy = 0; dataIn = '0;
    endtask

    task automatic arm(input logic [DECW-1:0] d, input logic [LENW-1:0] l);
        decim = d; cap_len = l; data_valid = 0;
        start = 1; tick(); start = 0;
        trig = 1; tick(); trig = 0;
    endtask

    task automatic feed(input logic [DW-1:0] v);
        data_valid = 1; dataIn = v; tick(); data_valid = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(name, done, 1);
    endtask

    // Transferred samples are checked in order against the expected stream.
    always @(negedge clk) begin
        if (mon_en && !rst && out_en && !outbusy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_extra: got %0h expected none", dsoutdata);
            end else begin
                check("stream", dsoutdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        tab[0] = '{14'h0000, 14'h2000};
        tab[1] = '{14'h0001, 14'h2001};
        tab[2] = '{14'h3FFF, 14'h1FFF};
        tab[3] = '{14'h2000, 14'h0000};
        tab[4] = '{14'h1FFF, 14'h3FFF};
        tab[5] = '{14'h0064, 14'h2064};

        clear_inputs();
        decim = '0; cap_len = '0;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
        trig_level = '0; trig_sel = 0;
`endif
        rst = 1; tick(); tick(); rst = 0;
        check("rst_data", dsoutdata, 0);
        check("rst_out_en", out_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);

        // Conversion table, decim 0, one output per input one cycle later.
        arm(0, 6);
        check("armed_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            feed(tab[i].din);
            check($sformatf("conv_%0d", i), dsoutdata, tab[i].exp);
            check($sformatf("conv_en_%0d", i), out_en, 1);
        end
        wait_done("conv_done", 5);
        check("conv_out_en_low", out_en, 0);
        check("conv_busy_low", busy, 0);

        // Ramp with decim 2, cap_len 3: keep 0, 3, 6; later samples ignored.
        mon_en = 1;
        arm(2, 3);
        exp_q.push_back(ofs(0)); exp_q.push_back(ofs(3)); exp_q.push_back(ofs(6));
        for (int v = 0; v < 10; v++) feed(DW'(v));
        wait_done("ramp_done", 5);
        check("ramp_q_empty", exp_q.size(), 0);

        // Randomized runs: stream model from index arithmetic on valid samples.
        for (int run = 0; run < 6; run++) begin
            int d, l, k, emitted, cyc;
            d = $urandom_range(0, 3);
            l = $urandom_range(1, 8);
            arm(DECW'(d), LENW'(l));
            k = 0; emitted = 0; cyc = 0;
            while (emitted < l && cyc < 500) begin
                data_valid = ($urandom_range(0, 3) != 0);
                dataIn = DW'($urandom);
                if (data_valid) begin
                    if (k % (d + 1) == 0) begin
                        exp_q.push_back(ofs(dataIn));
                        emitted++;
                    end
                    k++;
                end
                tick();
                cyc++;
            end
            data_valid = 0;
            wait_done($sformatf("rand_done_%0d", run), 5);
            check($sformatf("rand_q_empty_%0d", run), exp_q.size(), 0);
            check($sformatf("rand_overrun_%0d", run), overrun, 0);
        end

        // Stall: first sample held, kept samples during stall dropped.
        arm(0, 3);
        exp_q.push_back(ofs(10)); exp_q.push_back(ofs(50)); exp_q.push_back(ofs(60));
        feed(10);
        outbusy = 1;
        feed(20); feed(30); feed(40);
        check("stall_hold", dsoutdata, ofs(10));
        check("stall_en", out_en, 1);
        check("stall_overrun", overrun, 1);
        check("stall_busy", busy, 1);
        outbusy = 0;
        feed(50); feed(60);
        wait_done("stall_done", 5);
        check("stall_q_empty", exp_q.size(), 0);
        check("stall_overrun_kept", overrun, 1);
        mon_en = 0;

        // Abort while holding a sample.
        arm(0, 0);
        check("rearm_overrun_clr", overrun, 0);
        feed(14'h0123);
        check("abort_pre_en", out_en, 1);
        outbusy = 1; abort = 1; data_valid = 1; tick();
        abort = 0; data_valid = 0; outbusy = 0;
        check("abort_en", out_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        arm(0, 2);
        feed(7);
        check("post_abort_d0", dsoutdata, ofs(7));
        feed(8);
        check("post_abort_d1", dsoutdata, ofs(8));
        wait_done("post_abort_done", 5);

        // start with trig in the same cycle: trig ignored.
        start = 1; trig = 1; tick(); start = 0; trig = 0;
        check("st_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            feed(DW'(i + 1));
            check($sformatf("st_no_out_%0d", i), out_en, 0);
        end
        trig = 1; data_valid = 1; dataIn = 5; tick(); trig = 0; data_valid = 0;
        check("trig_cycle_not_captured", out_en, 0);
        feed(9);
        check("late_trig_data", dsoutdata, ofs(9));
        abort = 1; tick(); abort = 0;
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        check("start_abort_idle", busy, 0);
        trig = 1; tick(); trig = 0;
        feed(3);
        check("start_abort_no_out", out_en, 0);

        // Reset in the middle of a capture with a pending output.
        arm(0, 0);
        feed(14'h0555);
        rst = 1; tick(); rst = 0;
        check("midrst_en", out_en, 0);
        check("midrst_data", dsoutdata, 0);
        check("midrst_busy", busy, 0);

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
        trig_sel = 1; trig_level = 14'd100; decim = 0; cap_len = 0;
        start = 1; tick(); start = 0;
        feed(50); feed(99);
        check("lvl_no_fire", out_en, 0);
        feed(100);
        check("lvl_cross_not_captured", out_en, 0);
        feed(120);
        check("lvl_first_out", dsoutdata, 14'h2078);
        check("lvl_first_en", out_en, 1);
        abort = 1; tick(); abort = 0; trig_sel = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences one ADC sample stream into the downstream output port as a triggered, decimated capture burst.
- Each run follows arm, trigger, capture N samples, drain, done.
- Converts signed two's-complement ADC samples to offset binary (MSB inverted) before output.
- Sits between the ADC sample register and the output consumer, using the existing out_en/outbusy handshake.

Parameters:
- DATA_WIDTH, 14, ADC sample width.
- DEC_W, 8, width of decimation control.
- LEN_W, 16, width of capture-length control.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- dataIn  input  DATA_WIDTH  signed ADC sample.
- data_valid  input  1  dataIn is a new sample this cycle.
- decim  input  DEC_W  keep 1 of every decim+1 samples; sampled at start.
- cap_len  input  LEN_W  samples to emit; 0 means continuous; sampled at start.
- start  input  1  single-cycle arm request.
- abort  input  1  single-cycle abort.
- trig  input  1  external trigger.
- dsoutdata  output  DATA_WIDTH  offset-binary sample, registered.
- out_en  output  1  dsoutdata valid.
- outbusy  input  1  consumer stall.
- busy  output  1  state is not IDLE or DONE.
- done  output  1  sticky; capture complete.
- overrun  output  1  sticky; a kept sample was dropped.

Behaviour:
- Reset values:
  - dsoutdata = 0, out_en = 0, busy = 0, done = 0, overrun = 0.
  - State = IDLE; all counters 0.
- Conversion: dsoutdata = {~dataIn[MSB], dataIn[MSB-1:0]}. Examples: -8192 -> 0x0000, 0 -> 0x2000, 8191 -> 0x3FFF.
- Holding register (1 entry) drives dsoutdata/out_en.
  - Transfer occurs on any cycle with out_en=1 and outbusy=0.
  - A new kept sample may load on the same cycle as a transfer.
  - After a transfer with no load, out_en falls the next cycle.
- Latency: kept sample with data_valid at cycle t appears on dsoutdata, with out_en=1, at t+1.
- Drop rule: a kept sample arriving while the holding register is full and not transferring is dropped.
  - overrun is set.
  - The sample does not count toward cap_len.
  - The decimation phase still advances.
- State machine:
  - IDLE: on start, latch decim/cap_len, clear done and overrun, go ARMED.
  - ARMED: on trig, go CAPTURE; clear decimation counter and emitted count.
    - A trig in the same cycle as start is ignored.
    - A data_valid in the trig cycle is not captured.
  - CAPTURE: on each data_valid, keep the sample if decimation counter = 0.
    - The counter counts 0..decim and wraps to 0; the first sample after trigger is always kept.
    - Emitted count increments per loaded sample.
    - When count reaches cap_len (cap_len ≠ 0) on a load, go DRAIN.
    - cap_len = 0: stay in CAPTURE until abort; the count wraps silently.
  - DRAIN: ignore data_valid; when the holding register is empty (or empties this cycle), go DONE.
  - DONE: done = 1, busy = 0. On start, behave as IDLE (re-arm). Otherwise hold.
- abort in any state except IDLE:
  - Next state IDLE; holding register cleared (out_en = 0 next cycle).
  - done stays 0; overrun is retained.
- Simultaneous start and abort: abort wins. start in ARMED/CAPTURE/DRAIN is ignored.
- decim = 0: every sample kept.
- decim and cap_len changes outside IDLE/DONE have no effect.
- rst mid-capture returns everything to reset values next cycle, including a pending out_en.

Optional Feature:
- Macro: ADC_CAPTURE_LEVEL_TRIG_EN.
- When defined:
  - Adds input trig_level (DATA_WIDTH, signed) and input trig_sel (1).
  - With trig_sel = 1, ARMED fires on a rising crossing: previous valid sample < trig_level and current valid sample ≥ trig_level, signed compare.
  - The crossing sample is not captured.
  - The previous-sample register is cleared to the most negative value on entering ARMED.
  - With trig_sel = 0, external trig is used.
- When undefined: ports absent, only external trig.

Test Plan:
- Reset, start, trig, decim = 0, cap_len = 4, data_valid every cycle with dataIn = 0, 1, -1, -8192, outbusy = 0 -> dsoutdata 0x2000, 0x2001, 0x1FFF, 0x0000 on consecutive cycles, 1 cycle after each input; done = 1 after the drain.
- decim = 2, cap_len = 3, dataIn ramp 0..9 -> outputs offset of 0, 3, 6; then DONE; samples 7..9 ignored.
- outbusy held high for 3 cycles during decim = 0 capture -> first sample held on dsoutdata with out_en = 1; following kept samples dropped, overrun = 1, emitted count unchanged; capture completes after release.
- abort asserted in CAPTURE with out_en = 1 -> out_en = 0, busy = 0, done = 0 next cycle; a new start/trig works normally.
- start and trig in the same cycle, then no trig -> stays ARMED, no out_en; a later trig starts capture; start together with abort -> remains IDLE.
- (Macro defined) trig_sel = 1, trig_level = 100, input 50, 99, 100, 120 -> trigger on the 100 sample; first output is the 120 sample (0x2078).
